cordic_scheduler: RTL and testbench
===================================

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one cordic pipeline.
REQ-002 SHALL have parameter CORDIC_LAT, default 8: cycles from cordic_angle sampled to matching cordic_x/cordic_y valid.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester request; held with req_angle until granted.
REQ-006 SHALL have port req_angle  input  32*N_REQ  signed angle per requester (0..65535 = 0..360 deg), slice i = bits [32i+31:32i].
REQ-007 SHALL have port gnt  output  N_REQ  one-hot grant; request consumed in a cycle where req[i] && gnt[i].
REQ-008 SHALL have port drain  input  1  stop granting and empty the pipeline.
REQ-009 SHALL have port cordic_angle  output  32  registered angle to the cordic.
REQ-010 SHALL have ports cordic_x, cordic_y  input  32 each  signed cordic results.
REQ-011 SHALL have port rsp_valid  output  N_REQ  one-hot, one-cycle result strobe to the owning requester.
REQ-012 SHALL have ports rsp_x, rsp_y  output  32 each  registered result, valid when rsp_valid != 0.
REQ-013 SHALL have port busy  output  1  high while any issue is in flight; drained  output  1  high in DRAINED state.

Function
REQ-014 SHALL grant at most one requester per cycle, combinationally from req, state and round-robin pointer.
REQ-015 SHALL arbitrate round-robin: search starts at pointer; after a grant to i, pointer <= (i+1) mod N_REQ; pointer unchanged when no grant.
REQ-016 SHALL register the granted angle into cordic_angle on the grant edge; with no grant, cordic_angle <= 0.
REQ-017 SHALL carry {issue_valid, requester index} through a CORDIC_LAT-deep shift register aligned with cordic_angle.
REQ-018 SHALL, when the shift-register tail is valid with index k, register rsp_x <= cordic_x, rsp_y <= cordic_y, rsp_valid <= one-hot(k) next edge; total req-grant-to-rsp_valid latency = CORDIC_LAT+2 cycles.
REQ-019 SHALL hold rsp_x/rsp_y at last value and rsp_valid = 0 when tail not valid.
REQ-020 SHALL keep an in-flight counter, width clog2(CORDIC_LAT+2), +1 on grant, -1 on response, unchanged on simultaneous grant and response; busy = (count != 0).
REQ-021 SHALL implement FSM RUN, DRAIN, DRAINED: RUN->DRAIN when drain=1; DRAIN->DRAINED when count=0 and no grant; DRAINED->RUN when drain=0; DRAIN->RUN if drain deasserts before empty.
REQ-022 SHALL grant only in RUN; grant and drain rising in same cycle: grant suppressed.
REQ-023 SHALL sustain one issue per cycle back-to-back; requester may re-request the cycle after its grant.
REQ-024 SHALL ignore req from a requester while not granted (no queueing inside block).

Reset
REQ-025 SHALL on reset clear gnt, rsp_valid, rsp_x, rsp_y, cordic_angle, shift-register valids and counter to 0, pointer to 0, state to RUN.
REQ-026 SHALL discard all in-flight issues on reset mid-operation; no rsp_valid for them afterwards.

Structure
REQ-027 SHALL place state enumeration and default parameter constants in shared package cordic_pkg.
REQ-028 SHALL use one sub-module rr_arbiter (N_REQ-wide round-robin grant with pointer update).
REQ-029 SHALL not instantiate the cordic; integration connects ports at top level.

Verification
REQ-030 Single: req[2]=1, angle 8192 -> gnt[2] same cycle, cordic_angle=8192 next edge, rsp_valid=4'b0100 at grant+CORDIC_LAT+2 with model cordic_x/y passed through.
REQ-031 Contention: req=4'b1111 held 8 cycles, pointer 0 -> grants 0,1,2,3,0,1,2,3; responses in same order, one per cycle.
REQ-032 Drain: 3 issues in flight, drain=1 -> gnt=0, busy falls after 3rd rsp, drained=1 next cycle; drain=0 -> RUN, grants resume.
REQ-033 Reset mid-flight: reset 1 cycle after 2 grants -> no rsp_valid in next 2*CORDIC_LAT cycles, busy=0, pointer 0.
REQ-034 Simultaneous grant and response each cycle for 20 cycles -> counter constant at CORDIC_LAT+1, no tag mismatch vs scoreboard.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and FSM encoding for the cordic request scheduler.
package cordic_pkg;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_CORDIC_LAT = 8;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; the search starts at ptr, which moves just past the winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [IW-1:0] ptr;

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr) + off) % N;
      if (en && !any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (any)
      ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/cordic_scheduler.sv
// Shares one external cordic pipeline among N_REQ requesters; a tag pipe
// tracks which requester owns each result as it emerges.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int CORDIC_LAT = DEF_CORDIC_LAT
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [32*N_REQ-1:0]     req_angle,
  output logic [N_REQ-1:0]        gnt,
  input  logic                    drain,
  output logic [31:0]             cordic_angle,
  input  logic signed [31:0]      cordic_x,
  input  logic signed [31:0]      cordic_y,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic signed [31:0]      rsp_x,
  output logic signed [31:0]      rsp_y,
  output logic                    busy,
  output logic                    drained
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(CORDIC_LAT + 2);

  state_t                       state;
  logic                         grant_en, any_gnt, tail;
  logic [IW-1:0]                gnt_idx, tail_idx;
  logic [31:0]                  angle_sel;
  logic [CORDIC_LAT:0]          vld_pipe;
  logic [CORDIC_LAT:0][IW-1:0]  idx_pipe;
  logic [CW-1:0]                count;

  // Drain suppresses grants in the very cycle it rises, not one cycle later.
  assign grant_en = !reset && (state == ST_RUN) && !drain;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (grant_en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_gnt)
  );

  always_comb begin
    angle_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) angle_sel |= req_angle[32*i +: 32];
  end

  // Stage 0 lines up with cordic_angle; the tail lines up with cordic_x/y.
  assign tail     = vld_pipe[CORDIC_LAT];
  assign tail_idx = idx_pipe[CORDIC_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      cordic_angle <= '0;
      vld_pipe     <= '0;
      idx_pipe     <= '0;
    end else begin
      cordic_angle <= angle_sel;
      vld_pipe     <= {vld_pipe[CORDIC_LAT-1:0], any_gnt};
      idx_pipe     <= {idx_pipe[CORDIC_LAT-1:0], gnt_idx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        rsp_valid[i] <= tail && (tail_idx == IW'(i));
      if (tail) begin
        rsp_x <= cordic_x;
        rsp_y <= cordic_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      state   <= ST_RUN;
      drained <= 1'b0;
    end else begin
      case ({any_gnt, tail})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case (state)
        ST_RUN:
          if (drain) state <= ST_DRAIN;
        ST_DRAIN:
          if (!drain)
            state <= ST_RUN;
          else if (count == '0 && !any_gnt) begin
            state   <= ST_DRAINED;
            drained <= 1'b1;
          end
        ST_DRAINED:
          if (!drain) begin
            state   <= ST_RUN;
            drained <= 1'b0;
          end
        default: begin
          state   <= ST_RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (count != '0);
endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with a delay-line cordic model and an issue scoreboard.
module tb_cordic_scheduler;
  localparam int N = 4;
  localparam int L = 8;

  logic                 clk = 1'b0, reset = 1'b1, drain = 1'b0;
  logic [N-1:0]         req = '0;
  logic [32*N-1:0]      req_angle = '0;
  logic [N-1:0]         gnt, rsp_valid;
  logic [31:0]          cordic_angle;
  logic signed [31:0]   cordic_x, cordic_y, rsp_x, rsp_y;
  logic                 busy, drained;
  int                   total = 0, bad = 0, cyc = 0;
  logic [31:0]          dl [L];

  typedef struct { int idx; logic [31:0] ang; int cyc; } iss_t;
  iss_t q[$];

  cordic_scheduler #(.N_REQ(N), .CORDIC_LAT(L)) dut (
    .clk(clk), .reset(reset), .req(req), .req_angle(req_angle), .gnt(gnt),
    .drain(drain), .cordic_angle(cordic_angle), .cordic_x(cordic_x),
    .cordic_y(cordic_y), .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .busy(busy), .drained(drained)
  );

  always #5 clk = ~clk;

  // Cordic stand-in: samples cordic_angle each edge, result appears L cycles later.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    dl[0] <= cordic_angle;
    for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
  end
  assign cordic_x = dl[L-1] * 32'd3 + 32'd7;
  assign cordic_y = dl[L-1] ^ 32'h5555_5555;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((busy || q.size() != 0 || rsp_valid != '0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", 32'(i < budget), 32'd1);
  endtask

  // Scoreboard: every consumed grant must come back once, in order, L+2 cycles later.
  always @(negedge clk) begin
    iss_t e;
    if (reset) q.delete();
    else begin
      if (rsp_valid != '0) begin
        if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = q.pop_front();
          chk("rsp_owner", 32'(rsp_valid), 32'(1 << e.idx));
          chk("rsp_x", rsp_x, e.ang * 32'd3 + 32'd7);
          chk("rsp_y", rsp_y, e.ang ^ 32'h5555_5555);
          chk("rsp_latency", cyc, e.cyc + L + 2);
        end
      end
      for (int i = 0; i < N; i++)
        if (req[i] && gnt[i]) begin
          e.idx = i;
          e.ang = req_angle[32*i +: 32];
          e.cyc = cyc;
          q.push_back(e);
        end
    end
  end

  initial begin
    bit fin;
    fin = 1'b0;

    // Reset state, with requests already pending
    req = 4'b1111;
    repeat (2) next();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_x", rsp_x, 32'd0);
    chk("rst_cordic_angle", cordic_angle, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    next();
    reset = 1'b0;
    req   = '0;

    // Single request from requester 2
    req = 4'b0100;
    req_angle[64 +: 32] = 32'd8192;
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h4);
    next();
    req = '0;
    @(negedge clk);
    chk("single_angle", cordic_angle, 32'd8192);
    chk("single_busy", 32'(busy), 32'd1);
    next();
    @(negedge clk);
    chk("single_angle_idle", cordic_angle, 32'd0);
    repeat (L - 1) @(negedge clk);
    chk("single_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_x", rsp_x, 32'd24583);
    chk("single_rsp_y", rsp_y, 32'h5555_7555);
    chk("single_busy_done", 32'(busy), 32'd0);
    next();

    // Reset one cycle after two grants (pointer sits at 3)
    req = 4'b0011;
    req_angle[0 +: 32]  = 32'd111;
    req_angle[32 +: 32] = 32'd222;
    @(negedge clk);
    chk("flush_gnt0", 32'(gnt), 32'h1);
    next();
    @(negedge clk);
    chk("flush_gnt1", 32'(gnt), 32'h2);
    next();
    req   = '0;
    reset = 1'b1;
    next();
    reset = 1'b0;
    for (int c = 0; c < 2*L; c++) begin
      @(negedge clk);
      chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
      chk("flush_busy", 32'(busy), 32'd0);
      next();
    end

    // Contention from pointer 0
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_angle[32*i +: 32] = 32'(1000 + i);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("cont_gnt", 32'(gnt), 32'(1 << (c % 4)));
      next();
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("cont_rsp_early", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("cont_rsp_order", 32'(rsp_valid), 32'(1 << (k % 4)));
    end
    next();

    // Drain with three issues in flight
    req = 4'b0111;
    for (int i = 0; i < 3; i++) req_angle[32*i +: 32] = 32'(500 + i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("drain_issue_gnt", 32'(gnt), 32'(1 << c));
      next();
    end
    req   = 4'b1111;
    drain = 1'b1;
    @(negedge clk);
    chk("drain_same_cycle_gnt", 32'(gnt), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    next();
    for (int i = 0; i < 30 && !fin; i++) begin
      @(negedge clk);
      chk("drain_gnt", 32'(gnt), 32'd0);
      if (!busy) fin = 1'b1;
      else next();
    end
    chk("drain_busy_fall", 32'(fin), 32'd1);
    chk("drain_last_rsp", 32'(rsp_valid), 32'h4);
    chk("drain_not_yet", 32'(drained), 32'd0);
    next();
    @(negedge clk);
    chk("drained_set", 32'(drained), 32'd1);
    chk("drained_gnt", 32'(gnt), 32'd0);
    next();
    drain = 1'b0;
    @(negedge clk);
    chk("undrain_gnt_wait", 32'(gnt), 32'd0);
    chk("undrain_drained", 32'(drained), 32'd1);
    next();
    @(negedge clk);
    chk("resume_gnt", 32'(gnt), 32'h8);
    chk("resume_drained", 32'(drained), 32'd0);
    next();
    req = '0;
    wait_idle(40);
    next();

    // Sustained issue: grant and response every cycle
    req = 4'b1111;
    for (int k = 0; k < L + 21; k++) begin
      for (int i = 0; i < N; i++) req_angle[32*i +: 32] = 32'(100*k + i);
      @(negedge clk);
      chk("sustain_gnt", 32'(gnt), 32'(1 << (k % 4)));
      if (k >= L + 1) chk("sustain_count", 32'(dut.count), 32'(L + 1));
      next();
    end
    req = '0;
    wait_idle(40);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
